// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encoding, iterative-unit
// state encoding and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADDU  = 4'b0100;
    localparam logic [3:0] OP_SUBU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLTU  = 4'b1101;
    localparam logic [3:0] OP_SLL   = 4'b1110;
    localparam logic [3:0] OP_SRA   = 4'b1111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // Multiply and divide share the 10xx corner of the op space.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes,
// with a final sign-correction cycle. done is high for exactly one cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | waiting for start; operands latched on start
//   MD_ITER | WIDTH shift-add or shift-subtract steps, cnt counts down
//   MD_FIX  | sign-corrected lo/hi presented with done=1
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             ovf
);
    localparam int SHW = $clog2(WIDTH);

    md_state_t        state, state_nxt;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, dsor;
    logic             is_div_r, neg_lo_r, neg_hi_r, ovf_r;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   add_sum, rem_sh, trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // Operand magnitudes; the most negative value maps onto itself, which
    // is exactly 2^(WIDTH-1) when read as unsigned.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
    end

    // One multiply step (add then shift right) and one divide step
    // (shift left then trial subtract).
    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dsor} : '0);
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        trial   = rem_sh - {1'b0, dsor};
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= MD_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; flush always returns to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start)      state_nxt = MD_ITER;
            MD_ITER: if (cnt == '0)  state_nxt = MD_FIX;
            MD_FIX:                  state_nxt = MD_IDLE;
            default:                 state_nxt = MD_IDLE;
        endcase
        if (flush) state_nxt = MD_IDLE;
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            dsor     <= '0;
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (state == MD_IDLE && start) begin
            cnt      <= SHW'(WIDTH - 1);
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            dsor     <= mag_b;
            is_div_r <= is_div(op);
            neg_lo_r <= a_neg ^ b_neg;
            neg_hi_r <= a_neg;
            ovf_r    <= (op == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        end else if (state == MD_ITER) begin
            cnt <= cnt - 1'b1;
            if (is_div_r) begin
                if (!trial[WIDTH]) begin
                    acc_hi <= trial[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= rem_sh[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Sign correction: the product is negated as a whole, while quotient and
    // remainder follow the operand-sign and dividend-sign rules respectively.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_lo_r ? -prod : prod;
        lo       = is_div_r ? (neg_lo_r ? -acc_lo : acc_lo) : prod_fix[WIDTH-1:0];
        hi       = is_div_r ? (neg_hi_r ? -acc_hi : acc_hi) : prod_fix[2*WIDTH-1:WIDTH];
        ovf      = ovf_r;
        busy     = (state != MD_IDLE);
        done     = (state == MD_FIX);
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshakes. Single-cycle ops and divide by
// zero complete at the accept edge; multiply/divide run in muldiv_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             div_zero,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    logic             accept, md_start, md_busy, md_done, md_ovf;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] sum, diff, sc_res, sc_hi;
    logic             sc_ovf, sc_dz;
    logic [SHW-1:0]   shamt;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .start   (md_start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (md_busy),
        .done    (md_done),
        .lo      (md_lo),
        .hi      (md_hi),
        .ovf     (md_ovf)
    );

    // Handshake; flush kills any acceptance in the same cycle.
    always_comb begin
        in_ready = !md_busy && (!out_valid || out_ready);
        accept   = in_valid && in_ready && !flush;
        md_start = accept && is_muldiv(op) && !(is_div(op) && (b == '0));
        busy     = md_busy;
    end

    // Single-cycle datapath, including the divide-by-zero shortcut.
    always_comb begin
        sum    = a + b;
        diff   = a - b;
        shamt  = b[SHW-1:0];
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        case (op)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_ADDU: sc_res = sum;
            OP_SUBU: sc_res = diff;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  sc_res[0] = $signed(a) < $signed(b);
            OP_SLTU: sc_res[0] = a < b;
            OP_SLL:  sc_res = a << shamt;
            OP_SRA:  sc_res = $signed(a) >>> shamt;
            OP_DIV, OP_DIVU: begin
                sc_res = '1;
                sc_hi  = a;
                sc_dz  = 1'b1;
            end
            default: sc_res = '0;
        endcase
    end

    // Output register: flush, then iterative result, then single-cycle
    // result, then consumer drain; outputs otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            hi        <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (md_done) begin
            out_valid <= 1'b1;
            result    <= md_lo;
            hi        <= md_hi;
            zero      <= (md_lo == '0);
            ovf       <= md_ovf;
            div_zero  <= 1'b0;
        end else if (accept && !md_start) begin
            out_valid <= 1'b1;
            result    <= sc_res;
            hi        <= sc_hi;
            zero      <= (sc_res == '0);
            ovf       <= sc_ovf;
            div_zero  <= sc_dz;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32: directed cases with literal expectations
// plus randomized traffic scored against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready, out_valid, zero, ovf, div_zero, busy;
    logic [31:0] result, hi;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        v;
        logic        d;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .ovf       (ovf),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: what each op must produce, from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx, sy, s;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        e.r = 32'd0; e.h = 32'd0; e.v = 1'b0; e.d = 1'b0; e.lat = 1; e.acc = 0;
        case (o)
            4'd0:  e.r = x & y;
            4'd1:  e.r = x | y;
            4'd2:  begin s = sx + sy; e.r = s[31:0]; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3:  e.r = x ^ y;
            4'd4:  e.r = x + y;
            4'd5:  e.r = x - y;
            4'd6:  begin s = sx - sy; e.r = s[31:0]; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  e.r = (sx < sy) ? 32'd1 : 32'd0;
            4'd8:  begin s = sx * sy; e.r = s[31:0]; e.h = s[63:32]; e.lat = W + 2; end
            4'd9:  begin p = ux * uy; e.r = p[31:0]; e.h = p[63:32]; e.lat = W + 2; end
            4'd10: begin
                if (y == 32'd0) begin
                    e.r = 32'hFFFF_FFFF; e.h = x; e.d = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.r = x; e.h = 32'd0; e.v = 1'b1; e.lat = W + 2;
                end else begin
                    s = sx / sy; e.r = s[31:0];
                    s = sx % sy; e.h = s[31:0];
                    e.lat = W + 2;
                end
            end
            4'd11: begin
                if (y == 32'd0) begin
                    e.r = 32'hFFFF_FFFF; e.h = x; e.d = 1'b1;
                end else begin
                    p = ux / uy; e.r = p[31:0];
                    p = ux % uy; e.h = p[31:0];
                    e.lat = W + 2;
                end
            end
            4'd12: e.r = ~(x | y);
            4'd13: e.r = (ux < uy) ? 32'd1 : 32'd0;
            4'd14: e.r = x << y[4:0];
            default: begin s = sx >>> y[4:0]; e.r = s[31:0]; end
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every cycle, outputs must match what the queued
    // transactions imply; then account for this cycle's handshakes.
    always @(negedge clock) begin
        exp_t e;
        logic vis, pend;
        if (!reset_n) begin
            q.delete();
        end else begin
            vis  = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat - 1);
            pend = (q.size() > 0) && (q[0].lat > 1) && !vis;
            chk("out_valid", 64'(out_valid), 64'(vis));
            chk("busy", 64'(busy), 64'(pend));
            chk("in_ready", 64'(in_ready), 64'(!pend && (!vis || out_ready)));
            if (vis) begin
                chk("result", 64'(result), 64'(q[0].r));
                chk("hi", 64'(hi), 64'(q[0].h));
                chk("zero", 64'(zero), 64'(q[0].z));
                chk("ovf", 64'(ovf), 64'(q[0].v));
                chk("div_zero", 64'(div_zero), 64'(q[0].d));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (vis && out_ready) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    e = model(op, a, b);
                    e.acc = cyc + 1;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one op with out_ready high; returns cycles until out_valid.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        int n;
        step();
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(n < 200), 64'(1));
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int seen;

        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        repeat (2) step();
        reset_n = 1'b1;

        issue(4'd2, 32'h7FFF_FFFF, 32'd1, lat);
        chk("add_lat", 64'(lat), 64'(1));
        chk("add_res", 64'(result), 64'h8000_0000);
        chk("add_ovf", 64'(ovf), 64'(1));
        chk("add_zero", 64'(zero), 64'(0));
        issue(4'd6, 32'd5, 32'd5, lat);
        chk("sub_zero", 64'(zero), 64'(1));

        issue(4'd8, 32'hFFFF_FFFD, 32'd5, lat);
        chk("mult_lat", 64'(lat), 64'(34));
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(result), 64'hFFFF_FFF1);
        issue(4'd9, 32'hFFFF_FFFD, 32'd5, lat);
        chk("multu_hi", 64'(hi), 64'h4);
        chk("multu_lo", 64'(result), 64'hFFFF_FFF1);

        issue(4'd10, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_q", 64'(result), 64'hFFFF_FFFD);
        chk("div_r", 64'(hi), 64'hFFFF_FFFF);
        issue(4'd10, 32'd9, 32'd0, lat);
        chk("dz_lat", 64'(lat), 64'(1));
        chk("dz_flag", 64'(div_zero), 64'(1));
        chk("dz_res", 64'(result), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(hi), 64'd9);
        issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("divovf_ovf", 64'(ovf), 64'(1));
        chk("divovf_res", 64'(result), 64'h8000_0000);

        // Back-pressure: ADD result must hold while a queued XOR stalls.
        step();
        out_ready = 1'b0;
        op = 4'd2; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        step();
        op = 4'd3; a = 32'd6; b = 32'd3;
        repeat (3) step();
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_res", 64'(result), 64'd3);
        chk("stall_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("stall_next_valid", 64'(out_valid), 64'(1));
        chk("stall_next_res", 64'(result), 64'd5);
        step();
        chk("stall_drain", 64'(out_valid), 64'(0));

        // Asynchronous reset in the middle of a multiply.
        op = 4'd8; a = 32'd3; b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_flags", 64'({result, hi} | {zero, ovf, div_zero}), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) step();
        reset_n = 1'b1;
        issue(4'd4, 32'd1, 32'd1, lat);
        chk("addu_lat", 64'(lat), 64'(1));
        chk("addu_res", 64'(result), 64'd2);

        issue(4'd13, 32'd1, 32'hFFFF_FFFF, lat);
        chk("sltu", 64'(result), 64'd1);
        issue(4'd7, 32'd1, 32'hFFFF_FFFF, lat);
        chk("slt", 64'(result), 64'd0);
        issue(4'd15, 32'h8000_0000, 32'd4, lat);
        chk("sra", 64'(result), 64'hF800_0000);

        // Flush in the middle of a divide.
        step();
        op = 4'd10; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        flush = 1'b1;
        op = 4'd2; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("flush_no_output", 64'(seen), 64'(0));

        // Flush wins over an otherwise legal accept.
        op = 4'd4; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_beats_accept", 64'(out_valid), 64'(0));

        for (int i = 0; i < 800; i++) begin
            step();
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = 4'($urandom_range(0, 15));
            a         = pick();
            b         = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        chk("drained", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
